regf_dump: RTL



---
 rtl/regf_pkg.sv | 15 +
 rtl/regf_dump.sv | 109 ++++++++++
 2 files changed

// File: rtl/regf_pkg.sv
// Shared sizing and FSM state type for the register-file dump client.
package regf_pkg;

  localparam int unsigned REGF_AW    = 5;
  localparam int unsigned REGF_DW    = 32;
  localparam int unsigned REGF_NREGS = 32;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StSend,
    StDone
  } dump_state_e;

endpackage

// File: rtl/regf_dump.sv
// Walks the register file through one async read port and streams each value out on valid/ready.
// Build option REGF_DUMP_SKIP_X0_EN starts the walk at x1, so x0 is not sent.
module regf_dump
  import regf_pkg::*;
#(
  parameter int unsigned NREGS = REGF_NREGS,
  parameter int unsigned AW    = REGF_AW,
  parameter int unsigned DW    = REGF_DW
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_start,
  output logic          o_busy,
  output logic          o_done,
  output logic [AW-1:0] o_rf_raddr,
  input  logic [DW-1:0] i_rf_rdata,
  output logic          o_m_valid,
  input  logic          i_m_ready,
  output logic [DW-1:0] o_m_data,
  output logic [AW-1:0] o_m_index,
  output logic          o_m_last
);

`ifdef REGF_DUMP_SKIP_X0_EN
  localparam logic [AW-1:0] FirstIdx = AW'(1);
`else
  localparam logic [AW-1:0] FirstIdx = '0;
`endif
  localparam logic [AW-1:0] LastIdx = AW'(NREGS - 1);

  dump_state_e   r_state, w_state_d;
  logic [AW-1:0] r_idx, w_idx_d;
  logic          r_m_valid, w_m_valid_d;
  logic [DW-1:0] r_m_data, w_m_data_d;
  logic [AW-1:0] r_m_index, w_m_index_d;
  logic          r_m_last, w_m_last_d;
  logic          w_done;

  always_comb begin
    w_state_d   = r_state;
    w_idx_d     = r_idx;
    w_m_valid_d = r_m_valid;
    w_m_data_d  = r_m_data;
    w_m_index_d = r_m_index;
    w_m_last_d  = r_m_last;
    w_done      = 1'b0;
    case (r_state)
      StIdle: begin
        if (i_start) begin
          w_idx_d   = FirstIdx;
          w_state_d = StLoad;
        end
      end
      StLoad: begin
        // Capture the async read now; later file writes must not disturb this word.
        w_m_data_d  = i_rf_rdata;
        w_m_index_d = r_idx;
        w_m_last_d  = (r_idx == LastIdx);
        w_m_valid_d = 1'b1;
        w_state_d   = StSend;
      end
      StSend: begin
        if (r_m_valid && i_m_ready) begin
          w_m_valid_d = 1'b0;
          if (r_idx == LastIdx) begin
            w_state_d = StDone;
          end else begin
            w_idx_d   = r_idx + 1'b1;
            w_state_d = StLoad;
          end
        end
      end
      StDone: begin
        w_done     = 1'b1;
        w_m_last_d = 1'b0;
        w_idx_d    = '0;
        w_state_d  = StIdle;
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= StIdle;
      r_idx     <= '0;
      r_m_valid <= 1'b0;
      r_m_data  <= '0;
      r_m_index <= '0;
      r_m_last  <= 1'b0;
    end else begin
      r_state   <= w_state_d;
      r_idx     <= w_idx_d;
      r_m_valid <= w_m_valid_d;
      r_m_data  <= w_m_data_d;
      r_m_index <= w_m_index_d;
      r_m_last  <= w_m_last_d;
    end
  end

  assign o_busy     = (r_state != StIdle);
  assign o_done     = w_done;
  assign o_rf_raddr = r_idx;
  assign o_m_valid  = r_m_valid;
  assign o_m_data   = r_m_data;
  assign o_m_index  = r_m_index;
  assign o_m_last   = r_m_last;

endmodule
